commit_trace_monitor: RTL

Parametrised end-of-simulation monitor for the NPC core. It observes up to NR_COMMIT retiring instructions per cycle and detects the ebreak exit trap. It classifies the trap as good (a0 == 0) or bad, and runs a no-commit watchdog. It keeps a ring buffer of the last RING_DEPTH committed instructions (itrace) that the harness reads back after halt. It sits beside the writeback stage; its outputs feed the simulation harness and are fully synthesisable.

---
 rtl/commit_trace_monitor_pkg.sv | 19 +
 rtl/commit_trace_monitor_itrace.sv | 75 +++++++
 rtl/commit_trace_monitor.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/commit_trace_monitor_pkg.sv
// Shared types for the commit trace monitor.
// Monitor state, trap cause and the ebreak encoding.
package commit_trace_monitor_pkg;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } mon_state_e;

   typedef enum logic [1:0] {
      TRAP_NONE    = 2'd0,
      TRAP_GOOD    = 2'd1,
      TRAP_BAD     = 2'd2,
      TRAP_TIMEOUT = 2'd3
   } trap_cause_e;

   localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

endpackage

// File: rtl/commit_trace_monitor_itrace.sv
// Ring buffer of the most recent retired instructions.
// Several writes per cycle; reads are relative to the newest entry.
module commit_trace_monitor_itrace
   import commit_trace_monitor_pkg::*;
#(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned ILEN       = 32,
   parameter int unsigned RING_DEPTH = 16,
   parameter int unsigned NR_COMMIT  = 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NR_COMMIT-1:0]          wr_en_i,
   input  logic [NR_COMMIT*XLEN-1:0]     wr_pc_i,
   input  logic [NR_COMMIT*ILEN-1:0]     wr_inst_i,
   input  logic [$clog2(RING_DEPTH)-1:0] rd_idx_i,
   output logic [XLEN-1:0]               rd_pc_o,
   output logic [ILEN-1:0]               rd_inst_o,
   output logic                          rd_valid_o
);

   localparam int unsigned IDX_W  = $clog2(RING_DEPTH);
   localparam int unsigned FILL_W = IDX_W + 1;
   localparam int unsigned CW     = $clog2(NR_COMMIT + 1);
   localparam int unsigned SUM_W  = FILL_W + CW;

   logic [XLEN-1:0]   pc_mem_q   [RING_DEPTH];
   logic [ILEN-1:0]   inst_mem_q [RING_DEPTH];
   logic [IDX_W-1:0]  wp_q, wp_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [IDX_W-1:0]  slot [NR_COMMIT];
   logic [CW-1:0]     n_wr;
   logic [SUM_W-1:0]  fill_sum;
   logic [IDX_W-1:0]  rd_slot;

   // Pack enabled lanes in lane order from the write pointer.
   always_comb begin
      n_wr = '0;
      for (int i = 0; i < NR_COMMIT; i++) begin
         slot[i] = wp_q + IDX_W'(n_wr);
         if (wr_en_i[i]) n_wr = n_wr + CW'(1);
      end
      wp_d     = wp_q + IDX_W'(n_wr);
      fill_sum = SUM_W'(fill_q) + SUM_W'(n_wr);
      fill_d   = (fill_sum >= SUM_W'(RING_DEPTH)) ?
                 FILL_W'(RING_DEPTH) : FILL_W'(fill_sum);
   end

   // Write pointer and saturating fill count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wp_q   <= '0;
         fill_q <= '0;
      end else begin
         wp_q   <= wp_d;
         fill_q <= fill_d;
      end
   end

   // Entry storage; stale contents are hidden by the fill count.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NR_COMMIT; i++) begin
         if (wr_en_i[i]) begin
            pc_mem_q[slot[i]]   <= wr_pc_i[i*XLEN +: XLEN];
            inst_mem_q[slot[i]] <= wr_inst_i[i*ILEN +: ILEN];
         end
      end
   end

   assign rd_slot    = wp_q - IDX_W'(1) - rd_idx_i;
   assign rd_pc_o    = pc_mem_q[rd_slot];
   assign rd_inst_o  = inst_mem_q[rd_slot];
   assign rd_valid_o = FILL_W'(rd_idx_i) < fill_q;

endmodule

// File: rtl/commit_trace_monitor.sv
// End-of-simulation monitor: exit trap, watchdog and itrace.
// Sits beside writeback and reports to the harness.
module commit_trace_monitor
   import commit_trace_monitor_pkg::*;
#(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned ILEN       = 32,
   parameter int unsigned NR_COMMIT  = 1,
   parameter int unsigned RING_DEPTH = 16,
   parameter int unsigned TIMEOUT    = 100000,
   parameter int unsigned CNT_W      = 64
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NR_COMMIT-1:0]          commit_valid,
   input  logic [NR_COMMIT*XLEN-1:0]     commit_pc,
   input  logic [NR_COMMIT*ILEN-1:0]     commit_inst,
   input  logic [NR_COMMIT-1:0]          commit_exit,
   input  logic [XLEN-1:0]               a0,
   input  logic [$clog2(RING_DEPTH)-1:0] rd_idx,
   output logic [XLEN-1:0]               rd_pc,
   output logic [ILEN-1:0]               rd_inst,
   output logic                          rd_valid,
   output logic                          halted,
   output logic                          finish,
   output logic                          good_trap,
   output logic                          bad_trap,
   output logic                          timeout,
   output logic [XLEN-1:0]               exit_code,
   output logic [XLEN-1:0]               trap_pc,
   output logic [ILEN-1:0]               trap_inst,
   output logic [CNT_W-1:0]              commit_count,
   output logic [CNT_W-1:0]              cycle_count
);

   localparam logic [31:0] WD_LIM =
      (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

   mon_state_e        state_q, state_d;
   trap_cause_e       cause_q, cause_d;
   logic              finish_q, finish_d;
   logic [XLEN-1:0]   code_q, code_d;
   logic [XLEN-1:0]   tpc_q, tpc_d;
   logic [ILEN-1:0]   tinst_q, tinst_d;
   logic [XLEN-1:0]   last_pc_q, last_pc_d;
   logic [ILEN-1:0]   last_inst_q, last_inst_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cyc_q, cyc_d;
   logic [31:0]       wd_q, wd_d;

   logic [NR_COMMIT-1:0] acc;
   logic                 blocked;
   logic                 has_exit;
   logic [XLEN-1:0]      exit_pc;
   logic [ILEN-1:0]      exit_inst;
   logic [CNT_W-1:0]     n_acc;

   // Accept lanes up to and including the oldest exit lane.
   always_comb begin
      acc         = '0;
      blocked     = 1'b0;
      has_exit    = 1'b0;
      exit_pc     = '0;
      exit_inst   = '0;
      n_acc       = '0;
      last_pc_d   = last_pc_q;
      last_inst_d = last_inst_q;
      for (int i = 0; i < NR_COMMIT; i++) begin
         if (state_q == ST_RUN && commit_valid[i] && !blocked) begin
            acc[i]      = 1'b1;
            n_acc       = n_acc + CNT_W'(1);
            last_pc_d   = commit_pc[i*XLEN +: XLEN];
            last_inst_d = commit_inst[i*ILEN +: ILEN];
            if (commit_exit[i]) begin
               blocked   = 1'b1;
               has_exit  = 1'b1;
               exit_pc   = commit_pc[i*XLEN +: XLEN];
               exit_inst = commit_inst[i*ILEN +: ILEN];
            end
         end
      end
   end

   // Next state, counters, watchdog and trap capture.
   always_comb begin
      state_d  = state_q;
      cause_d  = cause_q;
      finish_d = 1'b0;
      code_d   = code_q;
      tpc_d    = tpc_q;
      tinst_d  = tinst_q;
      cnt_d    = cnt_q;
      cyc_d    = cyc_q;
      wd_d     = wd_q;
      if (state_q == ST_RUN) begin
         cyc_d = cyc_q + CNT_W'(1);
         cnt_d = cnt_q + n_acc;
         wd_d  = (|acc) ? 32'd0 : wd_q + 32'd1;
         if (has_exit) begin
            state_d  = ST_HALT;
            finish_d = 1'b1;
            cause_d  = (a0 == '0) ? TRAP_GOOD : TRAP_BAD;
            code_d   = a0;
            tpc_d    = exit_pc;
            tinst_d  = exit_inst;
         end else if (!(|acc) && TIMEOUT != 0 && wd_q == WD_LIM) begin
            state_d  = ST_HALT;
            finish_d = 1'b1;
            cause_d  = TRAP_TIMEOUT;
            code_d   = '0;
            tpc_d    = last_pc_q;
            tinst_d  = last_inst_q;
         end
      end
   end

   // State and monitor registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RUN;
         cause_q     <= TRAP_NONE;
         finish_q    <= 1'b0;
         code_q      <= '0;
         tpc_q       <= '0;
         tinst_q     <= '0;
         last_pc_q   <= '0;
         last_inst_q <= '0;
         cnt_q       <= '0;
         cyc_q       <= '0;
         wd_q        <= '0;
      end else begin
         state_q     <= state_d;
         cause_q     <= cause_d;
         finish_q    <= finish_d;
         code_q      <= code_d;
         tpc_q       <= tpc_d;
         tinst_q     <= tinst_d;
         last_pc_q   <= last_pc_d;
         last_inst_q <= last_inst_d;
         cnt_q       <= cnt_d;
         cyc_q       <= cyc_d;
         wd_q        <= wd_d;
      end
   end

   commit_trace_monitor_itrace #(
      .XLEN       (XLEN),
      .ILEN       (ILEN),
      .RING_DEPTH (RING_DEPTH),
      .NR_COMMIT  (NR_COMMIT)
   ) u_itrace (
      .clock      (clock),
      .reset      (reset),
      .wr_en_i    (acc),
      .wr_pc_i    (commit_pc),
      .wr_inst_i  (commit_inst),
      .rd_idx_i   (rd_idx),
      .rd_pc_o    (rd_pc),
      .rd_inst_o  (rd_inst),
      .rd_valid_o (rd_valid)
   );

   assign halted       = (state_q == ST_HALT);
   assign finish       = finish_q;
   assign good_trap    = (cause_q == TRAP_GOOD);
   assign bad_trap     = (cause_q == TRAP_BAD);
   assign timeout      = (cause_q == TRAP_TIMEOUT);
   assign exit_code    = code_q;
   assign trap_pc      = tpc_q;
   assign trap_inst    = tinst_q;
   assign commit_count = cnt_q;
   assign cycle_count  = cyc_q;

endmodule
